// File: rtl/warp_rr_selector.sv
// Round-robin warp selector: picks one ready warp per grant, holds the grant
// under backpressure, and rotates priority past each accepted warp.
module warp_rr_selector #(
  parameter int unsigned NUM_WARPS   = 8,
  parameter int unsigned STALL_CNT_W = 16,
  localparam int unsigned WID_W      = $clog2(NUM_WARPS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_WARPS-1:0]   req_i,
  input  logic                   flush_i,
  output logic                   grant_valid_o,
  input  logic                   grant_ready_i,
  output logic [WID_W-1:0]       grant_id_o,
  output logic [NUM_WARPS-1:0]   grant_onehot_o,
  output logic                   idle_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef enum logic {
    EMPTY,
    HOLD
  } state_e;

  state_e                 state_q, state_d;
  logic [WID_W-1:0]       ptr_q, ptr_d;
  logic [WID_W-1:0]       gid_q, gid_d;
  logic [NUM_WARPS-1:0]   goh_q, goh_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic                   handshake;
  logic [NUM_WARPS-1:0]   cand;
  logic                   hi_found, lo_found;
  logic [WID_W-1:0]       hi_idx, lo_idx, win_idx;

  // State register and registered grant/pointer/counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      gid_q   <= '0;
      goh_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      goh_q   <= goh_d;
      stall_q <= stall_d;
    end
  end

  // Handshake, pointer advance, candidate mask and stall counter
  always_comb begin
    handshake = (state_q == HOLD) && grant_ready_i;
    ptr_d     = ptr_q;
    if (handshake) begin
      ptr_d = (gid_q == WID_W'(NUM_WARPS - 1)) ? '0 : gid_q + 1'b1;
    end
    cand = '0;
    if (state_q == EMPTY) begin
      cand = req_i;
    end else if (handshake) begin
      cand = req_i & ~goh_q;
    end
    stall_d = stall_q;
    if ((state_q == HOLD) && !grant_ready_i && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Winner: first candidate at or above the (post-handshake) pointer, else lowest candidate
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      if (cand[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = WID_W'(i);
      end
      if (cand[i] && !hi_found && (WID_W'(i) >= ptr_d)) begin
        hi_found = 1'b1;
        hi_idx   = WID_W'(i);
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  // Next-state: take a new grant, hold under backpressure, flush to EMPTY
  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    goh_d   = goh_q;
    if ((state_q == EMPTY) || handshake) begin
      if (lo_found) begin
        state_d = HOLD;
        gid_d   = win_idx;
        goh_d   = NUM_WARPS'(1) << win_idx;
      end else begin
        state_d = EMPTY;
        gid_d   = '0;
        goh_d   = '0;
      end
    end
    if (flush_i) begin
      state_d = EMPTY;
      gid_d   = '0;
      goh_d   = '0;
    end
  end

  // Outputs
  always_comb begin
    grant_valid_o  = (state_q == HOLD);
    grant_id_o     = gid_q;
    grant_onehot_o = goh_q;
    idle_o         = (req_i == '0) && (state_q == EMPTY);
    stall_cnt_o    = stall_q;
  end

endmodule

// File: tb/tb_warp_rr_selector.sv
// Bench for warp_rr_selector: rotating-scan reference model checked every
// cycle, plus hand-computed literal expectations along a directed sequence.
module tb_warp_rr_selector;

  localparam int unsigned N  = 8;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic          flush = 1'b0;
  logic          ready = 1'b0;
  logic          gvalid;
  logic [2:0]    gid;
  logic [N-1:0]  gonehot;
  logic          idle;
  logic [SW-1:0] stall;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  warp_rr_selector #(.NUM_WARPS(N), .STALL_CNT_W(SW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .flush_i(flush),
    .grant_valid_o(gvalid), .grant_ready_i(ready), .grant_id_o(gid),
    .grant_onehot_o(gonehot), .idle_o(idle), .stall_cnt_o(stall)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit         m_valid = 1'b0;
  int         m_id = 0;
  int         m_ptr = 0;
  int         m_stall = 0;

  // First requesting warp found scanning upward from ptr with wraparound
  function automatic int pick(input logic [N-1:0] c, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (c[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] c;
    bit           hs;
    int           w;
    if (!rst_n) begin
      m_valid = 1'b0; m_id = 0; m_ptr = 0; m_stall = 0;
    end else begin
      hs = m_valid && ready;
      if (m_valid && !ready && m_stall < (1 << SW) - 1) m_stall++;
      if (hs) m_ptr = (m_id + 1) % N;
      if (!m_valid || hs) begin
        c = req;
        if (hs) c[m_id] = 1'b0;
        w = pick(c, m_ptr);
        m_valid = (w >= 0);
        m_id    = (w >= 0) ? w : 0;
      end
      if (flush) begin
        m_valid = 1'b0; m_id = 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [N-1:0] exp_oh;
    if (chk_en) begin
      exp_oh = m_valid ? (N'(1) << m_id) : '0;
      checks += 5;
      if (gvalid !== m_valid)
        begin errors++; $display("FAIL model_valid got %0d want %0d t=%0t", gvalid, m_valid, $time); end
      if (gid !== 3'(m_id))
        begin errors++; $display("FAIL model_id got %0d want %0d t=%0t", gid, m_id, $time); end
      if (gonehot !== exp_oh)
        begin errors++; $display("FAIL model_onehot got %h want %h t=%0t", gonehot, exp_oh, $time); end
      if (idle !== ((req == '0) && !m_valid))
        begin errors++; $display("FAIL model_idle got %0d t=%0t", idle, $time); end
      if (stall !== SW'(m_stall))
        begin errors++; $display("FAIL model_stall got %0d want %0d t=%0t", stall, m_stall, $time); end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    // Reset with no requests
    cyc(2);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    chk("rst_valid", gvalid, 0);
    chk("rst_id", gid, 0);
    chk("rst_idle", idle, 1);
    chk("rst_stall", stall, 0);

    // ptr=0, req 0xA0: grants 5, 7, 5
    req = 8'hA0; ready = 1'b1;
    cyc();
    chk("rr_id5", gid, 5);
    chk("rr_oh5", gonehot, 8'h20);
    cyc();
    chk("rr_id7", gid, 7);
    cyc();
    chk("rr_id5b", gid, 5);
    req = 8'h00;
    cyc();
    chk("rr_drain", gvalid, 0);

    // ptr=6, req 0x03: wrap to 0, then alternate 1,0,1
    req = 8'h03;
    cyc(); chk("wrap_0", gid, 0);
    cyc(); chk("wrap_1", gid, 1);
    cyc(); chk("wrap_0b", gid, 0);
    cyc(); chk("wrap_1b", gid, 1);
    req = 8'h00;
    cyc();
    chk("wrap_drain", gvalid, 0);

    // ptr=2: grant 2 held under backpressure while req toggles
    req = 8'h04; ready = 1'b0;
    cyc(); chk("bp_grant", gid, 2);
    req = 8'hFF; cyc();
    req = 8'h00; cyc();
    req = 8'hFF; cyc();
    chk("bp_hold_id", gid, 2);
    chk("bp_stall", stall, 3);
    ready = 1'b1;
    cyc(); chk("bp_ptr3", gid, 3);
    req = 8'h00;
    cyc(); chk("bp_drain", gvalid, 0);

    // ptr=4: flush while stalled, then re-grant
    req = 8'h10; ready = 1'b0;
    cyc(); chk("fl_grant", gid, 4);
    flush = 1'b1;
    cyc(); chk("fl_valid", gvalid, 0);
    flush = 1'b0;
    cyc(); chk("fl_regrant", gid, 4);
    chk("fl_regrant_v", gvalid, 1);

    // Flush coinciding with a handshake still advances ptr to 5
    req = 8'h30; ready = 1'b1; flush = 1'b1;
    cyc(); chk("flhs_valid", gvalid, 0);
    flush = 1'b0; ready = 1'b0;
    cyc(); chk("flhs_id", gid, 5);

    // Stall counter saturation
    cyc(20);
    chk("sat_stall", stall, 15);
    chk("sat_hold", gid, 5);

    // Reset during back-to-back grants
    req = 8'hFF; ready = 1'b1;
    cyc(3);
    rst_n = 1'b0;
    cyc();
    chk("mrst_valid", gvalid, 0);
    chk("mrst_id", gid, 0);
    chk("mrst_oh", gonehot, 0);
    chk("mrst_stall", stall, 0);
    rst_n = 1'b1; req = 8'h0C;
    cyc();
    chk("mrst_first", gid, 2);
    req = 8'h00;
    cyc(2);
    chk("end_idle", idle, 1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

endmodule
